// File: rtl/conv_pkg.sv
// Shared constants for the CNN layer sequencer: geometry, memory-select codes,
// FSM state encodings and 3x3 tap offsets.
package conv_pkg;

    localparam int unsigned IMG_W  = 64;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned POOL_W = 32;
    localparam int unsigned XY_W   = 6;
    localparam int unsigned IJ_W   = 5;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StConvTap   = 3'd1;
    localparam logic [2:0] StConvFlush = 3'd2;
    localparam logic [2:0] StConvWr    = 3'd3;
    localparam logic [2:0] StPoolRd    = 3'd4;
    localparam logic [2:0] StPoolDrain = 3'd5;
    localparam logic [2:0] StPoolWr    = 3'd6;
    localparam logic [2:0] StDone      = 3'd7;

    localparam logic [3:0] TAP_LAST  = 4'd8;
    localparam logic [3:0] POOL_LAST = 4'd3;

    // Column offset of tap k (k % 3 - 1).
    function automatic logic signed [1:0] tap_dx(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return -2'sd1;
            4'd2, 4'd5, 4'd8: return 2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

    // Row offset of tap k (k / 3 - 1).
    function automatic logic signed [1:0] tap_dy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: return -2'sd1;
            4'd6, 4'd7, 4'd8: return 2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Maps pixel (x,y) and kernel tap k to an input-image address plus an
// out-of-image flag; coordinates are widened so edges never alias.
module conv_tap_addr_gen
    import conv_pkg::*;
(
    input  logic [XY_W-1:0]   x_i,
    input  logic [XY_W-1:0]   y_i,
    input  logic [3:0]        k_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              pad_o
);

    localparam logic signed [ADDR_W:0] ImgWS = (ADDR_W+1)'(IMG_W);

    logic signed [ADDR_W:0] xc;
    logic signed [ADDR_W:0] yc;

    always_comb begin
        xc     = $signed((ADDR_W+1)'(x_i)) + (ADDR_W+1)'(tap_dx(k_i));
        yc     = $signed((ADDR_W+1)'(y_i)) + (ADDR_W+1)'(tap_dy(k_i));
        pad_o  = xc[ADDR_W] | yc[ADDR_W] | (xc >= ImgWS) | (yc >= ImgWS);
        addr_o = ADDR_W'(yc * ImgWS + xc);
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Sequencer for the 3x3 padded convolution into layer 0 followed by the
// 2x2/stride-2 max-pool into layer 1; drives all memory-side control.
module conv_layer_sched
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic              tap_valid,
    output logic [3:0]        tap_k,
    output logic              tap_pad,
    output logic              acc_clr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [2:0]        csel,
    output logic              pool_valid,
    output logic              pool_first
);

    logic [2:0]        state_q, state_d;
    logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
    logic [IJ_W-1:0]   i_q, i_d, j_q, j_d;
    logic [3:0]        tap_q, tap_d;
    logic [ADDR_W-1:0] iaddr_q;
    logic [ADDR_W-1:0] tap_addr;
    logic              tap_pad_now;
    logic              tap_valid_q, tap_pad_q, pool_valid_q, pool_first_q;
    logic [3:0]        tap_k_q;

    conv_tap_addr_gen u_tap_addr_gen (
        .x_i    (x_q),
        .y_i    (y_q),
        .k_i    (tap_q),
        .addr_o (tap_addr),
        .pad_o  (tap_pad_now)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        i_d     = i_q;
        j_d     = j_q;
        tap_d   = tap_q;
        case (state_q)
            StIdle: begin
                if (ready) begin
                    state_d = StConvTap;
                    tap_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            StConvTap: begin
                if (tap_q == TAP_LAST) begin
                    state_d = StConvFlush;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StConvFlush: state_d = StConvWr;
            StConvWr: begin
                // Counters wrap naturally to 0 after (63,63).
                x_d = x_q + 1'b1;
                if (x_q == '1) y_d = y_q + 1'b1;
                state_d = (x_q == '1 && y_q == '1) ? StPoolRd : StConvTap;
            end
            StPoolRd: begin
                if (tap_q == POOL_LAST) begin
                    state_d = StPoolDrain;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StPoolDrain: state_d = StPoolWr;
            StPoolWr: begin
                i_d = i_q + 1'b1;
                if (i_q == '1) j_d = j_q + 1'b1;
                state_d = (i_q == '1 && j_q == '1) ? StDone : StPoolRd;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        acc_clr  = (state_q == StConvTap) && (tap_q == '0);
        iaddr    = (state_q == StConvTap && !tap_pad_now) ? tap_addr : iaddr_q;
        crd      = (state_q == StPoolRd);
        // Window read: row 2j+p[1], column 2i+p[0] on a 64-wide image.
        caddr_rd = crd ? {j_q, tap_q[1], i_q, tap_q[0]} : '0;
        cwr      = 1'b0;
        caddr_wr = '0;
        csel     = CSEL_NONE;
        case (state_q)
            StConvWr: begin
                cwr      = 1'b1;
                csel     = CSEL_L0;
                caddr_wr = {y_q, x_q};
            end
            StPoolRd, StPoolDrain: csel = CSEL_L0;
            StPoolWr: begin
                cwr      = 1'b1;
                csel     = CSEL_L1;
                caddr_wr = ADDR_W'({j_q, i_q});
            end
            default: ;
        endcase
    end

    assign tap_valid  = tap_valid_q;
    assign tap_k      = tap_k_q;
    assign tap_pad    = tap_pad_q;
    assign pool_valid = pool_valid_q;
    assign pool_first = pool_first_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            tap_q        <= '0;
            iaddr_q      <= '0;
            tap_valid_q  <= 1'b0;
            tap_k_q      <= '0;
            tap_pad_q    <= 1'b0;
            pool_valid_q <= 1'b0;
            pool_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            i_q          <= i_d;
            j_q          <= j_d;
            tap_q        <= tap_d;
            iaddr_q      <= iaddr;
            tap_valid_q  <= (state_q == StConvTap);
            tap_k_q      <= (state_q == StConvTap) ? tap_q : '0;
            tap_pad_q    <= (state_q == StConvTap) && tap_pad_now;
            pool_valid_q <= (state_q == StPoolRd);
            pool_first_q <= (state_q == StPoolRd) && (tap_q == '0);
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: edge/interior pixels, pool windows,
// run length, mid-run reset and back-to-back start.
module tb_conv_layer_sched;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic        tap_valid;
    logic [3:0]  tap_k;
    logic        tap_pad;
    logic        acc_clr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [2:0]  csel;
    logic        pool_valid;
    logic        pool_first;

    int n_vec;
    int n_err;
    int cyc;
    int cyc_start;
    int exp_ia [9];

    conv_layer_sched u_dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .busy       (busy),
        .iaddr      (iaddr),
        .tap_valid  (tap_valid),
        .tap_k      (tap_k),
        .tap_pad    (tap_pad),
        .acc_clr    (acc_clr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .csel       (csel),
        .pool_valid (pool_valid),
        .pool_first (pool_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance n cycles, optionally pulsing ready (must be ignored while busy).
    task automatic skip(input int n, input bit poke);
        for (int c = 0; c < n; c++) begin
            ready = poke && (c % 97 == 5);
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " busy"}, 32'(busy), 0);
        check_eq({tag, " strobes"},
                 32'({tap_valid, tap_pad, acc_clr, crd, cwr, pool_valid, pool_first}), 0);
        check_eq({tag, " tap_k"}, 32'(tap_k), 0);
        check_eq({tag, " csel"}, 32'(csel), 0);
        check_eq({tag, " iaddr"}, 32'(iaddr), 0);
        check_eq({tag, " caddr_rd"}, 32'(caddr_rd), 0);
        check_eq({tag, " caddr_wr"}, 32'(caddr_wr), 0);
    endtask

    // Entered on a pixel's tap-0 cycle; leaves on the cycle after its write.
    task automatic check_pixel(input string tag, input logic [8:0] pad_mask, input int wr_addr);
        check_eq({tag, " acc_clr"}, 32'(acc_clr), 1);
        check_eq({tag, " busy"}, 32'(busy), 1);
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("%s iaddr k%0d", tag, k), 32'(iaddr), exp_ia[k]);
            tick();
            check_eq($sformatf("%s tap_valid k%0d", tag, k), 32'(tap_valid), 1);
            check_eq($sformatf("%s tap_k k%0d", tag, k), 32'(tap_k), k);
            check_eq($sformatf("%s tap_pad k%0d", tag, k), 32'(tap_pad), 32'(pad_mask[k]));
        end
        tick();
        check_eq({tag, " cwr"}, 32'(cwr), 1);
        check_eq({tag, " csel"}, 32'(csel), 1);
        check_eq({tag, " caddr_wr"}, 32'(caddr_wr), wr_addr);
        check_eq({tag, " wr tap_valid"}, 32'(tap_valid), 0);
        tick();
    endtask

    task automatic check_pool(input string tag, input int a0, input int a1, input int a2,
                              input int a3, input int wr_addr);
        int a [4];
        a = '{a0, a1, a2, a3};
        for (int p = 0; p < 4; p++) begin
            check_eq($sformatf("%s crd p%0d", tag, p), 32'(crd), 1);
            check_eq($sformatf("%s csel p%0d", tag, p), 32'(csel), 1);
            check_eq($sformatf("%s caddr_rd p%0d", tag, p), 32'(caddr_rd), a[p]);
            check_eq($sformatf("%s pool_valid p%0d", tag, p), 32'(pool_valid), 32'(p != 0));
            check_eq($sformatf("%s pool_first p%0d", tag, p), 32'(pool_first), 32'(p == 1));
            tick();
        end
        check_eq({tag, " drain pool_valid"}, 32'(pool_valid), 1);
        check_eq({tag, " drain pool_first"}, 32'(pool_first), 0);
        check_eq({tag, " drain crd"}, 32'(crd), 0);
        tick();
        check_eq({tag, " wr cwr"}, 32'(cwr), 1);
        check_eq({tag, " wr crd"}, 32'(crd), 0);
        check_eq({tag, " wr csel"}, 32'(csel), 3);
        check_eq({tag, " caddr_wr"}, 32'(caddr_wr), wr_addr);
        tick();
    endtask

    task automatic start_run();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        cyc_start = cyc;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();
        check_quiet("idle");

        // First run: pixel (0,0), interior (1,1), abort at pixel 100.
        start_run();
        exp_ia = '{0, 0, 0, 0, 0, 1, 1, 64, 65};
        check_pixel("px0", 9'b001001111, 0);
        skip(64 * 11, 1'b1);
        exp_ia = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
        check_pixel("px65", 9'b000000000, 65);
        skip(34 * 11, 1'b0);
        check_eq("px100 acc_clr", 32'(acc_clr), 1);
        skip(3, 1'b0);
        reset = 1'b1;
        tick();
        check_quiet("abort");
        reset = 1'b0;
        tick();
        check_quiet("abort idle");

        // Full run from the restart.
        start_run();
        exp_ia = '{0, 0, 0, 0, 0, 1, 1, 64, 65};
        check_pixel("restart px0", 9'b001001111, 0);
        skip(4094 * 11, 1'b1);
        exp_ia = '{4030, 4031, 4031, 4094, 4095, 4095, 4095, 4095, 4095};
        check_pixel("px4095", 9'b111100100, 4095);
        check_pool("pool0", 0, 1, 64, 65, 0);
        skip(1022 * 6, 1'b1);
        check_pool("pool1023", 4030, 4031, 4094, 4095, 1023);
        check_eq("done busy", 32'(busy), 1);
        check_eq("done cwr", 32'(cwr), 0);
        check_eq("done csel", 32'(csel), 0);
        ready = 1'b1;
        tick();
        check_eq("end busy", 32'(busy), 0);
        check_eq("run length", 32'(cyc - cyc_start + 1), 45056 + 6144 + 2);

        // ready still held: back-to-back start.
        tick();
        ready = 1'b0;
        check_eq("b2b busy", 32'(busy), 1);
        check_eq("b2b acc_clr", 32'(acc_clr), 1);
        skip(10, 1'b0);
        check_eq("b2b cwr", 32'(cwr), 1);
        check_eq("b2b csel", 32'(csel), 1);
        check_eq("b2b caddr_wr", 32'(caddr_wr), 0);
        reset = 1'b1;
        tick();
        check_quiet("final reset");
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
